// File: rtl/mem_dump_reader.sv
// mem_dump_reader
//   Debug-side reader for the MIPS data memory. A start pulse in IDLE walks
//   data memory words 0..WORD_COUNT-1 through a dedicated read port and
//   serialises each 32-bit word as four bytes, LSB first, onto a
//   valid/ready byte stream feeding the debug UART transmitter.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      one-cycle dump request, honoured only in IDLE
//   mem_addr   word address to the data RAM read port (held outside ADDR)
//   mem_en     RAM read enable, high only in the ADDR cycle
//   mem_rdata  RAM read data, valid RD_LAT clocks after the ADDR cycle
//   tx_data    byte to the UART transmitter
//   tx_valid   tx_data is valid
//   tx_ready   transmitter accepts the byte on this edge
//   busy       high while a dump is in progress
//   done       one-cycle pulse after the final byte is accepted
//
// All outputs are registered.
module mem_dump_reader #(
    parameter int ADDR_W     = 13,
    parameter int WORD_COUNT = 64,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORD_COUNT - 1);
    localparam logic [1:0]        LAT_INIT  = 2'(RD_LAT - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] word_cnt, word_cnt_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [1:0]        lat_cnt, lat_cnt_n;
    // Byte 0 goes straight from mem_rdata to tx_data, so only the upper
    // three bytes of the word need to be kept.
    logic [23:0]       word_hi, word_hi_n;
    logic              mem_en_n, tx_valid_n, busy_n, done_n;
    logic [7:0]        tx_data_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            byte_idx <= '0;
            lat_cnt  <= '0;
            word_hi  <= '0;
            mem_addr <= '0;
            mem_en   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            word_cnt <= word_cnt_n;
            byte_idx <= byte_idx_n;
            lat_cnt  <= lat_cnt_n;
            word_hi  <= word_hi_n;
            mem_addr <= mem_addr_n;
            mem_en   <= mem_en_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        word_cnt_n = word_cnt;
        byte_idx_n = byte_idx;
        lat_cnt_n  = lat_cnt;
        word_hi_n  = word_hi;
        mem_addr_n = mem_addr;
        mem_en_n   = 1'b0;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        busy_n     = busy;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = ADDR;
                    word_cnt_n = '0;
                    mem_addr_n = '0;
                    mem_en_n   = 1'b1;
                    busy_n     = 1'b1;
                end
            end

            ADDR: begin
                state_n   = WAIT;
                lat_cnt_n = LAT_INIT;
            end

            WAIT: begin
                if (lat_cnt == 2'd0) begin
                    word_hi_n  = mem_rdata[31:8];
                    byte_idx_n = 2'd0;
                    tx_data_n  = mem_rdata[7:0];
                    tx_valid_n = 1'b1;
                    state_n    = SEND;
                end else begin
                    lat_cnt_n = lat_cnt - 2'd1;
                end
            end

            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (byte_idx != 2'd3) begin
                        byte_idx_n = byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    tx_data_n = word_hi[7:0];
                            2'd1:    tx_data_n = word_hi[15:8];
                            default: tx_data_n = word_hi[23:16];
                        endcase
                    end else begin
                        tx_valid_n = 1'b0;
                        if (word_cnt == LAST_WORD) begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            // Address of the next word is registered here so
                            // that mem_en and mem_addr go out together in ADDR.
                            word_cnt_n = word_cnt + 1'b1;
                            mem_addr_n = word_cnt + 1'b1;
                            mem_en_n   = 1'b1;
                            state_n    = ADDR;
                        end
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader
//   Three instances: A (WORD_COUNT=64, RD_LAT=1) checked every cycle against a
//   byte-queue model; B (WORD_COUNT=1, RD_LAT=1) and C (WORD_COUNT=1,
//   RD_LAT=3) checked cycle by cycle against hand-written expectations.
module tb_mem_dump_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- instance A ----------------
    logic        a_start, a_mem_en, a_tx_valid, a_tx_ready, a_busy, a_done;
    logic [12:0] a_mem_addr;
    logic [31:0] a_rdata;
    logic [7:0]  a_tx_data;
    logic [31:0] mem_a [64];

    mem_dump_reader #(.ADDR_W(13), .WORD_COUNT(64), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .mem_addr(a_mem_addr), .mem_en(a_mem_en), .mem_rdata(a_rdata),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .busy(a_busy), .done(a_done)
    );

    // RAM model: data only valid for the one cycle it is due, garbage otherwise.
    logic        a_pv = 1'b0;
    logic [31:0] a_pd;
    always @(posedge clk) begin
        a_pv <= a_mem_en;
        a_pd <= (a_mem_addr < 13'd64) ? mem_a[a_mem_addr[5:0]] : 32'hBAD0BAD0;
    end
    assign a_rdata = a_pv ? a_pd : 32'hDEADBEEF;

    // ---------------- instance B ----------------
    logic        b_start, b_mem_en, b_tx_valid, b_tx_ready, b_busy, b_done;
    logic [12:0] b_mem_addr;
    logic [31:0] b_rdata;
    logic [7:0]  b_tx_data;

    mem_dump_reader #(.ADDR_W(13), .WORD_COUNT(1), .RD_LAT(1)) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .mem_addr(b_mem_addr), .mem_en(b_mem_en), .mem_rdata(b_rdata),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .busy(b_busy), .done(b_done)
    );

    logic        b_pv = 1'b0;
    logic [31:0] b_pd;
    always @(posedge clk) begin
        b_pv <= b_mem_en;
        b_pd <= (b_mem_addr == 13'd0) ? 32'hA1B2C3D4 : 32'hBAD0BAD0;
    end
    assign b_rdata = b_pv ? b_pd : 32'hDEADBEEF;

    // ---------------- instance C ----------------
    logic        c_start, c_mem_en, c_tx_valid, c_tx_ready, c_busy, c_done;
    logic [12:0] c_mem_addr;
    logic [31:0] c_rdata;
    logic [7:0]  c_tx_data;

    mem_dump_reader #(.ADDR_W(13), .WORD_COUNT(1), .RD_LAT(3)) dut_c (
        .clk(clk), .reset(reset), .start(c_start),
        .mem_addr(c_mem_addr), .mem_en(c_mem_en), .mem_rdata(c_rdata),
        .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
        .busy(c_busy), .done(c_done)
    );

    logic [2:0]  c_pv = 3'b000;
    logic [31:0] c_pd0, c_pd1, c_pd2;
    always @(posedge clk) begin
        c_pv  <= {c_pv[1:0], c_mem_en};
        c_pd0 <= (c_mem_addr == 13'd0) ? 32'h00000080 : 32'hBAD0BAD0;
        c_pd1 <= c_pd0;
        c_pd2 <= c_pd1;
    end
    assign c_rdata = c_pv[2] ? c_pd2 : 32'hDEADBEEF;

    // ---------------- model of A ----------------
    // Expected byte stream is a queue filled when a start is accepted; every
    // accepted byte must match its head. busy/done follow from the queue.
    logic [7:0] q[$];
    logic       chk_en = 1'b0;
    logic       m_busy = 1'b0, m_done = 1'b0, exp_rst = 1'b0;
    logic       p_hold = 1'b0;
    logic [7:0] p_data;
    int         m_addr = 0;

    always @(negedge clk) begin
        logic [31:0] w;
        logic        nd;
        if (chk_en) begin
            if (exp_rst) begin
                chk("a_rst_mem_addr", 32'(a_mem_addr), 32'd0);
                chk("a_rst_mem_en", 32'(a_mem_en), 32'd0);
                chk("a_rst_tx_data", 32'(a_tx_data), 32'd0);
                chk("a_rst_tx_valid", 32'(a_tx_valid), 32'd0);
                chk("a_rst_busy", 32'(a_busy), 32'd0);
                chk("a_rst_done", 32'(a_done), 32'd0);
            end else begin
                chk("a_busy", 32'(a_busy), 32'(m_busy));
                chk("a_done", 32'(a_done), 32'(m_done));
                if (a_mem_en) begin
                    chk("a_mem_addr", 32'(a_mem_addr), 32'(m_addr));
                    m_addr++;
                end
                if (p_hold) begin
                    chk("a_hold_valid", 32'(a_tx_valid), 32'd1);
                    chk("a_hold_data", 32'(a_tx_data), 32'(p_data));
                end
                if (a_tx_valid) begin
                    chk("a_byte_expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) chk("a_tx_data", 32'(a_tx_data), 32'(q[0]));
                end
            end
        end
        p_hold = a_tx_valid && !a_tx_ready && !reset;
        p_data = a_tx_data;
        if (reset) begin
            q.delete();
            m_busy  = 1'b0;
            m_done  = 1'b0;
            exp_rst = 1'b1;
            m_addr  = 0;
            p_hold  = 1'b0;
        end else begin
            exp_rst = 1'b0;
            nd = 1'b0;
            if (a_tx_valid && a_tx_ready && q.size() != 0) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_busy = 1'b0;
                    nd = 1'b1;
                end
            end
            if (a_start && !m_busy && !m_done) begin
                for (int i = 0; i < 64; i++) begin
                    w = mem_a[i];
                    for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
                end
                m_busy = 1'b1;
                m_addr = 0;
            end
            m_done = nd;
        end
    end

    // One A dump; k counts cycles after the start edge (cycle 1 = ADDR).
    task automatic a_run(input int sk1, input int sk2, input int rk,
                         input int exp_done_k, input int exp_men);
        int done_k = 0, dcnt = 0, men = 0, fv = 0, last_k;
        @(posedge clk); #1;
        a_start = 1'b1;
        a_ready_set(1'b1);
        last_k = (rk > 0) ? rk + 2 : 1000;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            a_start = (k == sk1) || (k == sk2);
            reset   = (k == rk);
            @(negedge clk);
            if (a_mem_en) men++;
            if (a_tx_valid && fv == 0) fv = k;
            if (a_done) begin
                dcnt++;
                if (done_k == 0) done_k = k;
            end
            if (rk > 0 && k == rk + 1) begin
                chk("a_reset_tx_valid", 32'(a_tx_valid), 32'd0);
                chk("a_reset_tx_data", 32'(a_tx_data), 32'd0);
                chk("a_reset_busy", 32'(a_busy), 32'd0);
                chk("a_reset_mem_addr", 32'(a_mem_addr), 32'd0);
            end
            if (done_k > 0 && k >= done_k + 3) break;
        end
        // Edge at which the first byte is registered (start edge = 0).
        chk("a_first_valid_edge", 32'(fv - 1), 32'd2);
        if (rk == 0) begin
            chk("a_done_cycle", 32'(done_k), 32'(exp_done_k));
            chk("a_done_pulses", 32'(dcnt), 32'd1);
        end
        chk("a_mem_en_count", 32'(men), 32'(exp_men));
    endtask

    task automatic a_ready_set(input logic r);
        a_tx_ready = r;
    endtask

    // One cycle of a B (inst 0) or C (inst 1) sequence.
    task automatic step(input int inst, input logic rdy, input logic ev,
                        input logic [7:0] ed, input logic edn, input logic eb,
                        input logic emen);
        logic v, dn, bz, me;
        logic [7:0] d;
        string p;
        @(posedge clk); #1;
        if (inst == 0) begin b_start = 1'b0; b_tx_ready = rdy; end
        else           begin c_start = 1'b0; c_tx_ready = rdy; end
        @(negedge clk);
        if (inst == 0) begin
            v = b_tx_valid; d = b_tx_data; dn = b_done; bz = b_busy; me = b_mem_en; p = "b_";
        end else begin
            v = c_tx_valid; d = c_tx_data; dn = c_done; bz = c_busy; me = c_mem_en; p = "c_";
        end
        chk({p, "tx_valid"}, 32'(v), 32'(ev));
        if (ev) chk({p, "tx_data"}, 32'(d), 32'(ed));
        chk({p, "done"}, 32'(dn), 32'(edn));
        chk({p, "busy"}, 32'(bz), 32'(eb));
        chk({p, "mem_en"}, 32'(me), 32'(emen));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] = i * 32'h01010101;
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_tx_ready = 1'b0; b_tx_ready = 1'b0; c_tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        chk("b_rst_mem_addr", 32'(b_mem_addr), 32'd0);
        chk("b_rst_tx_data", 32'(b_tx_data), 32'd0);
        chk("b_rst_tx_valid", 32'(b_tx_valid), 32'd0);
        chk("c_rst_busy", 32'(c_busy), 32'd0);
        chk("c_rst_done", 32'(c_done), 32'd0);
        chk("c_rst_mem_en", 32'(c_mem_en), 32'd0);

        // B: single word, tx_ready held high.
        @(posedge clk); #1 b_start = 1'b1;
        step(0, 1, 0, 8'h00, 0, 1, 1);
        step(0, 1, 0, 8'h00, 0, 1, 0);
        step(0, 1, 1, 8'hD4, 0, 1, 0);
        step(0, 1, 1, 8'hC3, 0, 1, 0);
        step(0, 1, 1, 8'hB2, 0, 1, 0);
        step(0, 1, 1, 8'hA1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0, 0);

        // B: backpressure for three cycles on byte 1.
        @(posedge clk); #1 b_start = 1'b1;
        step(0, 1, 0, 8'h00, 0, 1, 1);
        step(0, 1, 0, 8'h00, 0, 1, 0);
        step(0, 1, 1, 8'hD4, 0, 1, 0);
        step(0, 0, 1, 8'hC3, 0, 1, 0);
        step(0, 0, 1, 8'hC3, 0, 1, 0);
        step(0, 0, 1, 8'hC3, 0, 1, 0);
        step(0, 1, 1, 8'hC3, 0, 1, 0);
        step(0, 1, 1, 8'hB2, 0, 1, 0);
        step(0, 1, 1, 8'hA1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0, 0);

        // C: RD_LAT=3, first byte registered four edges after start.
        @(posedge clk); #1 c_start = 1'b1;
        step(1, 1, 0, 8'h00, 0, 1, 1);
        step(1, 1, 0, 8'h00, 0, 1, 0);
        step(1, 1, 0, 8'h00, 0, 1, 0);
        step(1, 1, 0, 8'h00, 0, 1, 0);
        step(1, 1, 1, 8'h80, 0, 1, 0);
        step(1, 1, 1, 8'h00, 0, 1, 0);
        step(1, 1, 1, 8'h00, 0, 1, 0);
        step(1, 1, 1, 8'h00, 0, 1, 0);
        step(1, 1, 0, 8'h00, 1, 0, 0);
        step(1, 1, 0, 8'h00, 0, 0, 0);

        // A: full dump; dump with stray starts (SEND of word 5, DONE cycle);
        // reset during word 10 byte 2; fresh dump afterwards.
        a_run(0, 0, 0, 385, 64);
        a_run(34, 385, 0, 385, 64);
        a_run(0, 0, 65, 0, 11);
        a_run(0, 0, 0, 385, 64);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
Debug-side reader for the MIPS data memory. On a start pulse it walks data memory words 0..WORD_COUNT-1 through a dedicated read port. It serialises each 32-bit word as four bytes, LSB first, over a valid/ready byte stream that feeds the UART transmitter of the debug unit. While busy is high, the debug unit muxes the data RAM address/enable to this block; the pipeline is halted by the debug unit, not by this block.

Parameters:
ADDR_W, 13, width of the word address into the data RAM.
WORD_COUNT, 64, number of words dumped per start; range 1..2^ADDR_W.
RD_LAT, 1, RAM read latency in clocks from the address cycle to valid mem_rdata; range 1..3.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
mem_addr  out  ADDR_W  word address to the data RAM read port.
mem_en  out  1  read enable to the RAM, high only in ADDR state.
mem_rdata  in  32  RAM read data, valid RD_LAT clocks after the ADDR cycle.
tx_data  out  8  byte to the UART transmitter.
tx_valid  out  1  tx_data is valid.
tx_ready  in  1  transmitter accepts the byte on this edge.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after the last byte of the last word is accepted.

Behaviour:
- Reset: state=IDLE. mem_addr=0, mem_en=0, tx_data=0, tx_valid=0, busy=0, done=0. Word counter, byte index and latency counter all cleared. Reset takes priority over every other event, including mid-dump and mid-byte. No partial byte completes after reset.
- All outputs are registered.
- States: IDLE, ADDR, WAIT, SEND, DONE.
- IDLE: if start=1, go to ADDR with word counter=0 and busy=1. Otherwise stay in IDLE.
- ADDR: one cycle. mem_en=1, mem_addr=word counter. Go to WAIT with latency counter=RD_LAT-1.
- WAIT: decrement the latency counter. When it is 0, capture mem_rdata into the word register, set byte index=0, tx_data=mem_rdata[7:0], tx_valid=1, and go to SEND.
- SEND: a transfer occurs on an edge where tx_valid=1 and tx_ready=1.
  - tx_data and tx_valid hold stable while tx_ready=0.
  - On a transfer with byte index <3: increment the index and present the next byte ([15:8], [23:16], [31:24]) with tx_valid still 1. There is no bubble between bytes.
  - On a transfer with index=3: drop tx_valid. If word counter=WORD_COUNT-1, go to DONE. Otherwise increment the word counter and go to ADDR.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle. Next state is IDLE.
- Latency: start accepted at edge E0. ADDR occupies the cycle after E0. The first tx_valid=1 is registered at edge E0+1+RD_LAT.
- Throughput with tx_ready held at 1: 4+1+RD_LAT cycles per word (4 byte cycles + ADDR + WAIT).
- A start arriving while not in IDLE, including in the DONE cycle, is ignored with no queueing.
- mem_addr holds its last value outside ADDR; only mem_en qualifies it.
- The word counter never exceeds WORD_COUNT-1, so there is no wrap.
- WORD_COUNT=1 gives a single word, then DONE.
- tx_ready high while tx_valid=0 has no effect.

Test Plan:
- Single word, RD_LAT=1, WORD_COUNT=1, mem[0]=32'hA1B2C3D4, tx_ready=1:
  - tx_valid first high 2 clocks after the start edge.
  - Bytes D4, C3, B2, A1 on consecutive cycles, then done pulse, then busy=0.
- Backpressure, same word:
  - tx_ready=0 for 3 cycles during byte 1 → tx_data stays C3 with tx_valid=1 throughout.
  - Byte order is unchanged and no byte is lost or duplicated.
- Full dump, WORD_COUNT=64, mem[i]=i*32'h01010101, tx_ready=1:
  - 256 bytes in order; mem_en asserted exactly 64 times with mem_addr 0..63.
  - done on cycle 1+64*6 after the start edge.
- start pulsed during SEND of word 5 → ignored; dump completes normally with exactly one done pulse.
- Reset asserted during SEND of word 10, byte 2:
  - Next cycle all outputs equal their reset values and state is IDLE.
  - A new start dumps again from word 0.
- RD_LAT=3, mem[0]=32'h00000080 → first tx_valid at edge E0+4 with tx_data=80; mem_rdata is not sampled before that edge.
